rtc_bus_sequencer: RTL and testbench

//  Owns the RTC's multiplexed 8-bit address/data bus and shares it between two requesters.

---
 rtl/rtc_bus_pkg.sv | 35 +++
 rtl/rtc_bus_phase_timer.sv | 26 ++
 rtl/rtc_bus_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed bus sequencer.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A_LO = 3'd1,
    ST_A_HI = 3'd2,
    ST_D_LO = 3'd3,
    ST_D_HI = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic {
    REQ_SCAN = 1'b0,
    REQ_WR   = 1'b1
  } req_t;

  // Time registers swept by the scanner, seconds through week number.
  localparam logic [7:0] REG_SEG = 8'h21;
  localparam logic [7:0] REG_MIN = 8'h22;
  localparam logic [7:0] REG_HOR = 8'h23;
  localparam logic [7:0] REG_DIA = 8'h24;
  localparam logic [7:0] REG_MES = 8'h25;
  localparam logic [7:0] REG_ANO = 8'h26;
  localparam logic [7:0] REG_DSM = 8'h27;
  localparam logic [7:0] REG_SEM = 8'h28;

  localparam logic       IDLE_CS_N   = 1'b1;
  localparam logic       IDLE_WR_N   = 1'b1;
  localparam logic       IDLE_RD_N   = 1'b1;
  localparam logic       IDLE_AD_OE  = 1'b0;
  localparam logic       IDLE_AD_SEL = 1'b0;
  localparam logic [7:0] IDLE_AD_OUT = 8'h00;

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; done is high while the count is zero.
module rtc_bus_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Owns the RTC multiplexed AD bus and alternates it between the periodic scanner and the write port.
// Handshake: wr_req is a level held with stable wr_addr/wr_data until the one-cycle wr_ack; rd_valid is a one-cycle strobe with no back-pressure.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int         T_LOW     = 4,
  parameter int         T_HIGH    = 4,
  parameter logic [7:0] SCAN_BASE = REG_SEG,
  parameter int         SCAN_LEN  = 8
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       per_tick,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       rd_valid,
  output logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       scan_busy,
  output logic       tick_ovr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad_sel,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output state_t     dbg_state
);

  localparam int T_MAX = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int IW    = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam logic [TW-1:0] LD_LOW   = TW'(T_LOW - 1);
  localparam logic [TW-1:0] LD_HIGH  = TW'(T_HIGH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(SCAN_LEN - 1);

  state_t        state, state_n;
  req_t          cur_req, last_grant, grant_req, nx_req;
  logic          grant;
  logic [7:0]    cur_addr, cur_wdata, nx_addr, scan_addr;
  logic [IW-1:0] scan_idx;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  logic          nx_cs_n, nx_wr_n, nx_rd_n, nx_ad_oe, nx_ad_sel;
  logic [7:0]    nx_ad_out;

  assign scan_addr = SCAN_BASE + 8'(scan_idx);
  assign dbg_state = state;

  rtc_bus_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    tmr_val   = LD_LOW;
    grant     = 1'b0;
    grant_req = REQ_WR;
    case (state)
      ST_IDLE: begin
        // With both pending, whoever did not win last time goes next.
        if (wr_req && scan_busy) begin
          grant     = 1'b1;
          grant_req = (last_grant == REQ_WR) ? REQ_SCAN : REQ_WR;
        end else if (wr_req) begin
          grant     = 1'b1;
          grant_req = REQ_WR;
        end else if (scan_busy) begin
          grant     = 1'b1;
          grant_req = REQ_SCAN;
        end
        if (grant) begin
          state_n  = ST_A_LO;
          tmr_load = 1'b1;
          tmr_val  = LD_LOW;
        end
      end
      ST_A_LO: if (tmr_done) begin state_n = ST_A_HI; tmr_load = 1'b1; tmr_val = LD_HIGH; end
      ST_A_HI: if (tmr_done) begin state_n = ST_D_LO; tmr_load = 1'b1; tmr_val = LD_LOW;  end
      ST_D_LO: if (tmr_done) begin state_n = ST_D_HI; tmr_load = 1'b1; tmr_val = LD_HIGH; end
      ST_D_HI: if (tmr_done) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so the registered pins line up with the FSM.
  always_comb begin
    nx_req    = grant ? grant_req : cur_req;
    nx_addr   = grant ? ((grant_req == REQ_WR) ? wr_addr : scan_addr) : cur_addr;
    nx_cs_n   = IDLE_CS_N;
    nx_wr_n   = IDLE_WR_N;
    nx_rd_n   = IDLE_RD_N;
    nx_ad_oe  = IDLE_AD_OE;
    nx_ad_sel = IDLE_AD_SEL;
    nx_ad_out = IDLE_AD_OUT;
    case (state_n)
      ST_A_LO: begin
        nx_cs_n = 1'b0; nx_ad_oe = 1'b1; nx_ad_out = nx_addr; nx_wr_n = 1'b0;
      end
      ST_A_HI: begin
        nx_cs_n = 1'b0; nx_ad_oe = 1'b1; nx_ad_out = nx_addr;
      end
      ST_D_LO: begin
        nx_cs_n   = 1'b0;
        nx_ad_sel = 1'b1;
        if (nx_req == REQ_WR) begin
          nx_ad_oe  = 1'b1;
          nx_ad_out = cur_wdata;
          nx_wr_n   = 1'b0;
        end else begin
          nx_rd_n = 1'b0;
        end
      end
      ST_D_HI: begin
        nx_cs_n = 1'b0; nx_ad_sel = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      cur_req    <= REQ_SCAN;
      last_grant <= REQ_SCAN;
      cur_addr   <= 8'h00;
      cur_wdata  <= 8'h00;
      scan_idx   <= '0;
      scan_busy  <= 1'b0;
      tick_ovr   <= 1'b0;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_addr    <= 8'h00;
      rd_data    <= 8'h00;
      cs_n       <= IDLE_CS_N;
      wr_n       <= IDLE_WR_N;
      rd_n       <= IDLE_RD_N;
      ad_oe      <= IDLE_AD_OE;
      ad_sel     <= IDLE_AD_SEL;
      ad_out     <= IDLE_AD_OUT;
    end else begin
      state    <= state_n;
      cs_n     <= nx_cs_n;
      wr_n     <= nx_wr_n;
      rd_n     <= nx_rd_n;
      ad_oe    <= nx_ad_oe;
      ad_sel   <= nx_ad_sel;
      ad_out   <= nx_ad_out;
      wr_ack   <= (state_n == ST_DONE) && (cur_req == REQ_WR);
      rd_valid <= (state_n == ST_DONE) && (cur_req == REQ_SCAN);
      if (grant) begin
        cur_req    <= grant_req;
        last_grant <= grant_req;
        cur_addr   <= nx_addr;
        cur_wdata  <= wr_data;
      end
      if (state == ST_D_LO && tmr_done && cur_req == REQ_SCAN) begin
        rd_addr <= cur_addr;
        rd_data <= ad_in;
      end
      if (state_n == ST_DONE && cur_req == REQ_SCAN) begin
        if (scan_idx == IDX_LAST) begin
          scan_idx  <= '0;
          scan_busy <= 1'b0;
        end else begin
          scan_idx <= scan_idx + IW'(1);
        end
      end
      // A tick during an active scan is dropped, not queued.
      if (per_tick) begin
        if (scan_busy) begin
          tick_ovr <= 1'b1;
        end else begin
          scan_busy <= 1'b1;
          scan_idx  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with a behavioural RTC that returns addr^8'hFF on reads.
module tb_rtc_bus_sequencer;
  import rtc_bus_pkg::*;

  localparam int T_LOW  = 2;
  localparam int T_HIGH = 2;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       per_tick = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, rd_valid, scan_busy, tick_ovr;
  logic [7:0] rd_addr, rd_data, ad_in, ad_out;
  logic       ad_oe, ad_sel, cs_n, wr_n, rd_n;
  state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rtc_bus_sequencer #(
    .T_LOW(T_LOW), .T_HIGH(T_HIGH), .SCAN_BASE(8'h21), .SCAN_LEN(8)
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .per_tick(per_tick),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .scan_busy(scan_busy), .tick_ovr(tick_ovr),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .ad_sel(ad_sel),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .dbg_state(dbg_state)
  );

  // ---------------- RTC model ----------------
  logic [7:0] model_addr;
  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) model_addr <= 8'h00;
    else if (!cs_n && !ad_sel && ad_oe && !wr_n) model_addr <= ad_out;
  end
  assign ad_in = rd_n ? 8'h00 : (model_addr ^ 8'hFF);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ev_w(input logic [7:0] a, input logic [7:0] d);
    return {2'b10, a, d};
  endfunction

  function automatic logic [17:0] ev_r(input logic [7:0] a, input logic last);
    return {1'b0, ~last, a, a ^ 8'hFF};
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  logic [7:0]  mon_addr = 8'h00;
  logic [7:0]  mon_wdata = 8'h00;
  int          rd_viol = 0;

  always @(negedge clk) begin
    logic [17:0] ev;
    if (!cs_n && !ad_sel && ad_oe) mon_addr = ad_out;
    if (!cs_n && ad_sel && ad_oe && !wr_n) mon_wdata = ad_out;
    if (!rd_n && (!ad_sel || ad_oe)) rd_viol++;
    if (wr_ack || rd_valid) begin
      ev = wr_ack ? {2'b10, mon_addr, mon_wdata} : {1'b0, scan_busy, rd_addr, rd_data};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got %h, expected no event", ev);
      end else begin
        check("bus_event", 32'(ev), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_tick();
    per_tick = 1'b1;
    @(negedge clk);
    per_tick = 1'b0;
  endtask

  task automatic run_until_empty(input int drop_after, input int budget, input string name);
    int acks = 0;
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
      if (wr_ack) begin
        acks++;
        if (acks >= drop_after) wr_req = 1'b0;
      end
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    wr_req = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic push_scan();
    logic [7:0] scan_addrs [8];
    scan_addrs = '{REG_SEG, REG_MIN, REG_HOR, REG_DIA, REG_MES, REG_ANO, REG_DSM, REG_SEM};
    for (int i = 0; i < 8; i++) exp_q.push_back(ev_r(scan_addrs[i], i == 7));
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic       cs_n, wr_n, rd_n, ad_oe, ad_sel;
    logic [7:0] ad_out;
    logic       wr_ack, chk_bus;
  } pin_vec_t;

  typedef struct {
    logic [7:0] addr, data;
  } wr_vec_t;

  pin_vec_t pin_tbl [10];
  wr_vec_t  wr_tbl [3];

  // ---------------- test sequence ----------------
  initial begin
    logic [13:0] act_v, exp_v;
    logic        found;

    pin_tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
    pin_tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
    pin_tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
    pin_tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
    pin_tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h45, 1'b0, 1'b1};
    pin_tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h45, 1'b0, 1'b1};
    pin_tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    pin_tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    pin_tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    pin_tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    wr_tbl[0] = '{8'hFF, 8'h00};
    wr_tbl[1] = '{8'h00, 8'hFF};
    wr_tbl[2] = '{8'h2A, 8'hA5};

    // Reset values
    #12;
    check("reset_pins", 32'({cs_n, wr_n, rd_n, ad_oe, ad_sel, ad_out}), 32'h1C00);
    check("reset_status", 32'({wr_ack, rd_valid, rd_addr, rd_data, scan_busy, tick_ovr}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single write, checked cycle by cycle from the grant edge
    exp_q.push_back(ev_w(8'h22, 8'h45));
    wr_addr = 8'h22;
    wr_data = 8'h45;
    wr_req  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      act_v = {cs_n, wr_n, rd_n, ad_oe, wr_ack, pin_tbl[k].chk_bus ? {ad_sel, ad_out} : 9'h000};
      exp_v = {pin_tbl[k].cs_n, pin_tbl[k].wr_n, pin_tbl[k].rd_n, pin_tbl[k].ad_oe, pin_tbl[k].wr_ack,
               pin_tbl[k].chk_bus ? {pin_tbl[k].ad_sel, pin_tbl[k].ad_out} : 9'h000};
      check($sformatf("t1_cycle%0d", k + 1), 32'(act_v), 32'(exp_v));
      if (wr_ack) wr_req = 1'b0;
    end
    run_until_empty(1, 50, "t1");

    // 1b: more writes from the table, including address/data extremes
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev_w(wr_tbl[i].addr, wr_tbl[i].data));
      wr_addr = wr_tbl[i].addr;
      wr_data = wr_tbl[i].data;
      wr_req  = 1'b1;
      run_until_empty(1, 50, $sformatf("t1b_write%0d", i));
    end

    // 2: full scan
    push_scan();
    pulse_tick();
    run_until_empty(1, 200, "t2_scan");
    check("t2_busy_after", 32'(scan_busy), 32'd0);
    check("t2_rd_n_addr_phase", 32'(rd_viol), 32'd0);

    // 3a: tick and write together, write released after its ack
    exp_q.push_back(ev_w(8'h23, 8'h17));
    push_scan();
    wr_addr = 8'h23;
    wr_data = 8'h17;
    wr_req  = 1'b1;
    pulse_tick();
    run_until_empty(1, 250, "t3a_order");

    // 3b: write held through the scan, alternation W R21 W R22 ...
    exp_q.push_back(ev_w(8'h2C, 8'h5A));
    exp_q.push_back(ev_r(REG_SEG, 1'b0));
    exp_q.push_back(ev_w(8'h2C, 8'h5A));
    exp_q.push_back(ev_r(REG_MIN, 1'b0));
    exp_q.push_back(ev_r(REG_HOR, 1'b0));
    exp_q.push_back(ev_r(REG_DIA, 1'b0));
    exp_q.push_back(ev_r(REG_MES, 1'b0));
    exp_q.push_back(ev_r(REG_ANO, 1'b0));
    exp_q.push_back(ev_r(REG_DSM, 1'b0));
    exp_q.push_back(ev_r(REG_SEM, 1'b1));
    wr_addr = 8'h2C;
    wr_data = 8'h5A;
    wr_req  = 1'b1;
    pulse_tick();
    run_until_empty(2, 300, "t3b_alternate");

    // 6: one-cycle write pulse while a scan read is on the bus
    push_scan();
    pulse_tick();
    repeat (3) @(negedge clk);
    wr_addr = 8'h30;
    wr_data = 8'h77;
    wr_req  = 1'b1;
    @(negedge clk);
    wr_req  = 1'b0;
    run_until_empty(1, 200, "t6_withdrawn");
    check("t6_tick_ovr_clear", 32'(tick_ovr), 32'd0);

    // 4: second tick mid-scan
    push_scan();
    pulse_tick();
    repeat (25) @(negedge clk);
    check("t4_busy_mid", 32'(scan_busy), 32'd1);
    pulse_tick();
    @(negedge clk);
    check("t4_ovr_set", 32'(tick_ovr), 32'd1);
    run_until_empty(1, 200, "t4_scan");
    repeat (20) @(negedge clk);
    check("t4_ovr_sticky", 32'(tick_ovr), 32'd1);

    // 5: reset in the data phase of a write
    wr_addr = 8'h24;
    wr_data = 8'h99;
    wr_req  = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == ST_D_LO) found = 1'b1;
    end
    check("t5_reach_d_lo", 32'(found), 32'd1);
    #2;
    Reset_n = 1'b0;
    wr_req  = 1'b0;
    #1;
    check("t5_pins_in_reset", 32'({cs_n, wr_n, ad_oe}), 32'b110);
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    check("t5_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_ovr_cleared", 32'(tick_ovr), 32'd0);
    repeat (12) @(negedge clk);
    exp_q.push_back(ev_w(8'h25, 8'h11));
    wr_addr = 8'h25;
    wr_data = 8'h11;
    wr_req  = 1'b1;
    run_until_empty(1, 50, "t5_after_reset");

    check("final_rd_n_addr_phase", 32'(rd_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
